word_serializer_arb: RTL and testbench
======================================

# word_serializer_arb

Two-requester word serializer controller for the transmit path. It arbitrates round-robin between two word sources and loads the granted word into an internal MSB-first shift-out datapath. It then sequences the word onto a byte-wide valid/ready stream, tagging each beat with its source and marking the final beat. It sits between the packet-assembly stages and the physical byte link.

## Interface
- WORD_WIDTH, 32, width of each source word; must be an integer multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, width of each output beat
- BEATS, WORD_WIDTH/BYTE_WIDTH, derived local parameter; data beats per word
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  source A holds a word
- a_data  in  WORD_WIDTH  source A word
- a_ready  out  1  source A word accepted this cycle (combinational)
- b_valid  in  1  source B holds a word
- b_data  in  WORD_WIDTH  source B word
- b_ready  out  1  source B word accepted this cycle (combinational)
- out_valid  out  1  out_data holds a valid beat
- out_data  out  BYTE_WIDTH  current beat, MSB-first slice of the word
- out_last  out  1  current beat is the final beat of the word
- out_src  out  1  source of the current word: 0 = A, 1 = B
- out_ready  in  1  downstream accepts the beat; the beat transfers on out_valid && out_ready
- busy  out  1  a word is in flight (state not IDLE)

## Operation
- States:
  - IDLE: out_valid = 0.
  - SEND: out_valid = 1.
  - PARITY: only with TX_PARITY_EN; out_valid = 1.
- Accept opportunity: the block can accept a word in IDLE, or in SEND/PARITY on the cycle the final beat transfers.
- Arbitration: performed only on an accept opportunity.
  - Only one source valid: that source is granted.
  - Both sources valid: the source named by the priority pointer is granted.
  - After any grant, the pointer moves to the other source.
  - The pointer resets to A.
- The granted source's ready is high for exactly that cycle. The other ready is 0. A ready never asserts without its valid.
- On a grant:
  - The word is loaded into the shift register.
  - out_src is registered.
  - The beat counter is cleared to 0.
  - The state becomes SEND.
- SEND:
  - out_data = shift register[WORD_WIDTH-1 : WORD_WIDTH-BYTE_WIDTH].
  - On each beat transfer, the register shifts left by BYTE_WIDTH and the counter increments.
  - out_last = (counter == BEATS-1) without parity.
- After the final beat transfers:
  - If a grant occurs in the same cycle, the block reloads and stays in SEND (zero-bubble).
  - Otherwise it goes to IDLE.
- When out_valid && !out_ready, out_data, out_last and out_src hold stable. out_valid is never withdrawn before the beat transfers.
- A source dropping its valid without a grant is legal; the block ignores it.
- Reset mid-word:
  - The word in flight is discarded; no partial completion.
  - All state returns to reset values.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_last = 0, out_src = 0, busy = 0, a_ready = 0, b_ready = 0, priority pointer = A, counter = 0.
- Latency: a word accepted in cycle N presents its first beat in cycle N+1.
- Throughput with out_ready held high:
  - BEATS cycles per word back-to-back.
  - BEATS+1 cycles per word with parity.
- a_ready and b_ready depend combinationally on a_valid, b_valid, the state, out_ready and the counter.
- Counter width is $clog2(BEATS+1). The counter never wraps; it is cleared on every load.

## Configuration
- TX_PARITY_EN defined:
  - After data beat BEATS-1 transfers, the block enters PARITY for one extra beat.
  - That beat's out_data = XOR of all BEATS data bytes of the word.
  - out_last is asserted on the parity beat only.
  - The accept opportunity moves to the parity beat's transfer.
  - The running XOR is accumulated as beats are loaded or shifted and is cleared on load.
- TX_PARITY_EN undefined:
  - PARITY state and accumulator are absent.
  - out_last is asserted on data beat BEATS-1.

## Test plan
- Single word: a_data = 32'hDEADBEEF, out_ready = 1.
  - a_ready pulses once.
  - Next four cycles: out_data = DE, AD, BE, EF; out_last only on EF; out_src = 0.
  - busy then drops.
- Contention: a_valid and b_valid both held with A = 32'h11223344, B = 32'h55667788 and fresh words each grant.
  - Grants alternate A, B, A, B.
  - First grant is A after reset.
  - No idle cycle between words.
- Backpressure: out_ready = 0 for 3 cycles during beat 2 of 32'hCAFEF00D.
  - out_data holds FE and out_valid stays 1.
  - Remaining beats follow in order; total word time is 7 cycles.
- Reset mid-word: assert rst after beat 1 of 32'h01020304.
  - All outputs are 0 immediately (asynchronous).
  - After release, a new word 32'hA0B0C0D0 emits A0 first.
- Parity (TX_PARITY_EN): word 32'h01020304.
  - Emits 01, 02, 03, 04, then 04 (1^2^3^4).
  - out_last only on the fifth beat.
- Idle sources: no valid for 20 cycles.
  - Readies stay 0, out_valid stays 0, busy stays 0.

Source files
------------

// File: rtl/word_serializer_arb.sv
// Two-source round-robin word serializer: MSB-first byte beats on a valid/ready stream.
// Optional trailing XOR parity beat enabled by defining TX_PARITY_EN.
module word_serializer_arb #(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [WORD_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [WORD_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  out_valid,
  output logic [BYTE_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_src,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int BEATS = WORD_WIDTH / BYTE_WIDTH;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  src_q, src_d;
  logic                  ptr_q, ptr_d;
  logic                  accept;
  logic                  grant_a;
  logic                  grant_b;
`ifdef TX_PARITY_EN
  logic [BYTE_WIDTH-1:0] par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      ptr_q   <= 1'b0;
`ifdef TX_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
`ifdef TX_PARITY_EN
    par_d     = par_q;
`endif
    accept    = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;

    case (state_q)
      IDLE: accept = 1'b1;
      SEND: begin
        out_valid = 1'b1;
        out_data  = shift_q[WORD_WIDTH-1 -: BYTE_WIDTH];
`ifndef TX_PARITY_EN
        out_last  = (cnt_q == LAST_CNT);
`endif
        if (out_ready) begin
          shift_d = shift_q << BYTE_WIDTH;
          cnt_d   = cnt_q + CW'(1);
`ifdef TX_PARITY_EN
          par_d   = par_q ^ shift_q[WORD_WIDTH-1 -: BYTE_WIDTH];
          if (cnt_q == LAST_CNT) state_d = PARITY;
`else
          if (cnt_q == LAST_CNT) begin
            accept  = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        out_valid = 1'b1;
        out_data  = par_q;
        out_last  = 1'b1;
        if (out_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Pointer only breaks ties; a lone valid source always wins.
    if (accept) begin
      if (a_valid && (!b_valid || !ptr_q)) grant_a = 1'b1;
      else if (b_valid)                    grant_b = 1'b1;
    end

    // A grant on the final transfer overrides the IDLE transition (zero-bubble reload).
    if (grant_a || grant_b) begin
      shift_d = grant_a ? a_data : b_data;
      src_d   = grant_b;
      ptr_d   = grant_a;
      cnt_d   = '0;
      state_d = SEND;
`ifdef TX_PARITY_EN
      par_d   = '0;
`endif
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign out_src = src_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_word_serializer_arb.sv
// Directed bench for word_serializer_arb: single word, contention, backpressure,
// asynchronous reset mid-word, optional parity beat and idle sources.
module tb_word_serializer_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, out_ready;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, out_valid, out_last, out_src, busy;
  logic [7:0]  out_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  word_serializer_arb #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic l, input logic s);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_last"},  32'(out_last),  32'(l));
    chk({tag, "_src"},   32'(out_src),   32'(s));
    chk({tag, "_busy"},  32'(busy),      32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_ardy"},  32'(a_ready),   32'd0);
    chk({tag, "_brdy"},  32'(b_ready),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    logic        s;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;
    repeat (2) step();

    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_src",  32'(out_src),  32'd0);
    chk_idle("rst");
    rst = 1'b0;
    #1;

    // Single word from A
    a_valid = 1'b1; a_data = 32'hDEADBEEF; out_ready = 1'b1;
    #1;
    chk("t1_ardy", 32'(a_ready), 32'd1);
    chk("t1_brdy", 32'(b_ready), 32'd0);
    chk("t1_busy0", 32'(busy), 32'd0);
    step();
    a_valid = 1'b0;
    #1;
    w = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      chk_beat("t1_beat", w[31-8*k -: 8], k == 3, 1'b0);
      chk("t1_ardy_low", 32'(a_ready), 32'd0);
      step();
    end
    chk_idle("t1_end");

    // Contention: after reset A wins first, then alternate with no bubble
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_valid = 1'b1; a_data = 32'h11223344;
    b_valid = 1'b1; b_data = 32'h55667788;
    #1;
    chk("t2_ardy0", 32'(a_ready), 32'd1);
    chk("t2_brdy0", 32'(b_ready), 32'd0);
    step();
    for (int wi = 0; wi < 4; wi++) begin
      s = (wi % 2 == 1);
      w = s ? 32'h55667788 : 32'h11223344;
      for (int k = 0; k < 4; k++) begin
        if (wi == 3 && k == 3) begin
          a_valid = 1'b0; b_valid = 1'b0;
          #1;
        end
        chk_beat("t2_beat", w[31-8*k -: 8], k == 3, s);
        if (k == 3 && wi < 3) begin
          chk("t2_ardy_next", 32'(a_ready), 32'(s));
          chk("t2_brdy_next", 32'(b_ready), 32'(!s));
        end else begin
          chk("t2_ardy_mid", 32'(a_ready), 32'd0);
          chk("t2_brdy_mid", 32'(b_ready), 32'd0);
        end
        step();
      end
    end
    chk_idle("t2_end");

    // Backpressure on the second beat for three cycles
    a_valid = 1'b1; a_data = 32'hCAFEF00D;
    #1;
    chk("t3_ardy", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    #1;
    chk_beat("t3_b0", 8'hCA, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk_beat("t3_stall", 8'hFE, 1'b0, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk_beat("t3_b1", 8'hFE, 1'b0, 1'b0);
    step();
    chk_beat("t3_b2", 8'hF0, 1'b0, 1'b0);
    step();
    chk_beat("t3_b3", 8'h0D, 1'b1, 1'b0);
    step();
    chk_idle("t3_end");

    // Reset in the middle of a B word
    b_valid = 1'b1; b_data = 32'h01020304;
    #1;
    chk("t4_brdy", 32'(b_ready), 32'd1);
    step();
    b_valid = 1'b0;
    #1;
    chk_beat("t4_b0", 8'h01, 1'b0, 1'b1);
    step();
    chk_beat("t4_b1", 8'h02, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_rst_data", 32'(out_data), 32'd0);
    chk("t4_rst_last", 32'(out_last), 32'd0);
    chk("t4_rst_src",  32'(out_src),  32'd0);
    chk_idle("t4_rst");
    step();
    rst = 1'b0;
    a_valid = 1'b1; a_data = 32'hA0B0C0D0;
    #1;
    chk("t4_ardy", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    #1;
    chk_beat("t4_new", 8'hA0, 1'b0, 1'b0);
    repeat (4) step();
    chk_idle("t4_end");

`ifdef TX_PARITY_EN
    // Trailing XOR parity beat
    a_valid = 1'b1; a_data = 32'h01020304;
    #1;
    chk("t5_ardy", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    #1;
    w = 32'h01020304;
    for (int k = 0; k < 4; k++) begin
      chk_beat("t5_beat", w[31-8*k -: 8], 1'b0, 1'b0);
      step();
    end
    chk_beat("t5_par", 8'h04, 1'b1, 1'b0);
    step();
    chk_idle("t5_end");
`endif

    // Idle sources
    for (int i = 0; i < 20; i++) begin
      chk_idle("t6_idle");
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
